// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg
// Shared types and widths for the fetch sequencer and its helpers.
// It provides:
//   - seq_state_e : the FSM state enum. Its encoding is exported on seq_state.
//   - STATE_W     : width of the state encoding.
//   - REG_IDX_W   : width of a register index.
//   - ADDR_W      : width of an address or offset.
package fetch_seq_pkg;

  localparam int STATE_W   = 3;
  localparam int REG_IDX_W = 5;
  localparam int ADDR_W    = 32;

  typedef enum logic [STATE_W-1:0] {
    ST_BOOT    = 3'd0,
    ST_RUN     = 3'd1,
    ST_LOADUSE = 3'd2,
    ST_MEMWAIT = 3'd3,
    ST_FLUSH   = 3'd4,
    ST_HALT    = 3'd5
  } seq_state_e;

endpackage

// File: rtl/fetch_sequencer_load_use_detect.sv
// load_use_detect
// Purely combinational load-use hazard detector. The forwarding unit can
// reuse it.
//
// A hazard exists when the EX-stage instruction is a load, its destination
// is not x0, and the decode-stage instruction reads that register.
//
// Ports:
//   id_rs1, id_rs2           : decode-stage source register indices
//   id_uses_rs1, id_uses_rs2 : decode instruction actually reads rs1 / rs2
//   ex_is_load               : EX-stage instruction is a load
//   ex_rd                    : EX-stage destination register index
//   hazard                   : load-use hazard present this cycle
module load_use_detect
  import fetch_seq_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic                 ex_is_load,
  input  logic [REG_IDX_W-1:0] ex_rd,
  output logic                 hazard
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);

  // x0 is hard-wired to zero, so a load into x0 can never create a dependency.
  assign hazard = ex_is_load && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Sequences the program counter and the IF/ID and ID/EX pipeline registers.
// It arbitrates three causes of a PC change, in priority order:
//   1. a taken branch redirect from EX;
//   2. an instruction-memory wait;
//   3. a load-use hazard.
// It also detects an instruction-fetch timeout, sets a sticky fault and
// halts the front end.
//
// Outputs are Mealy: combinational from the current state and inputs.
// The state and counters update on the rising clock edge.
//
// Parameters:
//   BRANCH_PENALTY : wrong-path cycles flushed after a taken branch (1..7)
//   MEM_TIMEOUT    : consecutive not-ready cycles before a fetch fault (1..255)
//
// Ports:
//   clock, reset          : rising-edge clock; asynchronous active-high reset
//   imem_req, imem_ready  : fetch request out; fetch data valid in
//   id_rs1, id_rs2,
//   id_uses_rs1/2         : decode-stage operand usage
//   ex_is_load, ex_rd     : EX-stage load and destination register
//   br_valid, br_taken,
//   br_offset             : EX branch resolution and offset
//   pc_stall, pc_succ,
//   pc_new_addr           : PC control (hold / take offset / offset value)
//   flush_ifid,
//   flush_idex,
//   stall_ifid            : pipeline register control
//   fetch_fault           : sticky fetch-timeout flag, cleared only by reset
//   seq_state             : current FSM state encoding
//
// Optional build macro FETCH_SEQ_PERF_EN adds two saturating counters:
//   perf_stall_cycles : cycles with pc_stall=1 outside BOOT
//   perf_redirects    : cycles with pc_succ=1
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int BRANCH_PENALTY = 2,
  parameter int MEM_TIMEOUT    = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 imem_req,
  input  logic                 imem_ready,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic                 ex_is_load,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 br_valid,
  input  logic                 br_taken,
  input  logic [ADDR_W-1:0]    br_offset,
  output logic                 pc_stall,
  output logic                 pc_succ,
  output logic [ADDR_W-1:0]    pc_new_addr,
  output logic                 flush_ifid,
  output logic                 flush_idex,
  output logic                 stall_ifid,
  output logic                 fetch_fault,
`ifdef FETCH_SEQ_PERF_EN
  output logic [31:0]          perf_stall_cycles,
  output logic [31:0]          perf_redirects,
`endif
  output logic [STATE_W-1:0]   seq_state
);

  // The FLUSH counter starts at BRANCH_PENALTY-1. The redirect cycle itself
  // is the first flushed wrong-path cycle.
  localparam logic [2:0] FLUSH_RELOAD = 3'(BRANCH_PENALTY - 1);
  localparam logic [8:0] TIMEOUT_LIM  = 9'(MEM_TIMEOUT);

  seq_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       fault_q, fault_d;

  logic       hz;
  logic       taken;
  logic [8:0] wcnt_inc;

  load_use_detect u_load_use_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_is_load  (ex_is_load),
    .ex_rd       (ex_rd),
    .hazard      (hz)
  );

  assign taken    = br_valid && br_taken;
  // One extra bit so that the timeout compare cannot wrap.
  assign wcnt_inc = {1'b0, wcnt_q} + 9'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wcnt_d      = wcnt_q;
    fault_d     = fault_q;
    imem_req    = 1'b0;
    pc_stall    = 1'b0;
    pc_succ     = 1'b0;
    pc_new_addr = '0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    stall_ifid  = 1'b0;

    case (state_q)
      ST_BOOT: begin
        pc_stall = 1'b1;
        state_d  = ST_RUN;
      end

      // RUN, LOADUSE and MEMWAIT all honour a taken branch first.
      ST_RUN, ST_LOADUSE, ST_MEMWAIT: begin
        imem_req = 1'b1;
        if (taken) begin
          // A redirect discards any pending fetch, including one in MEMWAIT.
          pc_succ     = 1'b1;
          pc_new_addr = br_offset;
          flush_ifid  = 1'b1;
          flush_idex  = 1'b1;
          wcnt_d      = '0;
          if (BRANCH_PENALTY == 1) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_RELOAD;
          end
        end else if (state_q == ST_MEMWAIT) begin
          if (imem_ready) begin
            wcnt_d  = '0;
            state_d = ST_RUN;
          end else begin
            pc_stall   = 1'b1;
            stall_ifid = 1'b1;
            flush_idex = 1'b1;
            wcnt_d     = wcnt_inc[7:0];
            if (wcnt_inc >= TIMEOUT_LIM) begin
              fault_d = 1'b1;
              state_d = ST_HALT;
            end
          end
        end else if (!imem_ready) begin
          // The first not-ready cycle counts toward the timeout.
          pc_stall   = 1'b1;
          stall_ifid = 1'b1;
          flush_idex = 1'b1;
          wcnt_d     = 8'd1;
          state_d    = ST_MEMWAIT;
        end else if (hz && (state_q == ST_RUN)) begin
          // In LOADUSE, EX already holds the bubble, so hz is masked.
          pc_stall   = 1'b1;
          stall_ifid = 1'b1;
          flush_idex = 1'b1;
          state_d    = ST_LOADUSE;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_FLUSH: begin
        // br_valid here belongs to a wrong-path instruction and is ignored.
        imem_req   = 1'b1;
        flush_ifid = 1'b1;
        if (!imem_ready) begin
          pc_stall = 1'b1;
        end else if (cnt_q <= 3'd1) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      ST_HALT: begin
        pc_stall   = 1'b1;
        stall_ifid = 1'b1;
        flush_idex = 1'b1;
      end

      default: begin
        pc_stall = 1'b1;
        state_d  = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_BOOT;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      fault_q <= fault_d;
    end
  end

  assign fetch_fault = fault_q;
  assign seq_state   = state_q;

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] perf_stall_cycles_q, perf_stall_cycles_d;
  logic [31:0] perf_redirects_q, perf_redirects_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    perf_stall_cycles_d = perf_stall_cycles_q;
    perf_redirects_d    = perf_redirects_q;
    if (pc_stall && (state_q != ST_BOOT)) begin
      perf_stall_cycles_d = sat_inc(perf_stall_cycles_q);
    end
    if (pc_succ) begin
      perf_redirects_d = sat_inc(perf_redirects_q);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_stall_cycles_q <= '0;
      perf_redirects_q    <= '0;
    end else begin
      perf_stall_cycles_q <= perf_stall_cycles_d;
      perf_redirects_q    <= perf_redirects_d;
    end
  end

  assign perf_stall_cycles = perf_stall_cycles_q;
  assign perf_redirects    = perf_redirects_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer.
// The bench has two parts:
//   - A behavioural model, stepped on every falling edge, that predicts all
//     outputs from the sequencing rules. It tracks "booted / halted / waiting /
//     flush cycles left / load-use shadow" as plain variables.
//   - Directed stimulus with hand-computed literal checks.
module tb_fetch_sequencer;

  localparam int BP = 2;
  localparam int MT = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic        imem_ready;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_is_load;
  logic        br_valid, br_taken;
  logic [31:0] br_offset;
  logic        pc_stall, pc_succ;
  logic [31:0] pc_new_addr;
  logic        flush_ifid, flush_idex, stall_ifid, fetch_fault;
  logic [2:0]  seq_state;
`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] perf_stall_cycles, perf_redirects;
  logic [31:0] m_perf_stall, m_perf_redir;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  fetch_sequencer #(.BRANCH_PENALTY(BP), .MEM_TIMEOUT(MT)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_ready  (imem_ready),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_is_load  (ex_is_load),
    .ex_rd       (ex_rd),
    .br_valid    (br_valid),
    .br_taken    (br_taken),
    .br_offset   (br_offset),
    .pc_stall    (pc_stall),
    .pc_succ     (pc_succ),
    .pc_new_addr (pc_new_addr),
    .flush_ifid  (flush_ifid),
    .flush_idex  (flush_idex),
    .stall_ifid  (stall_ifid),
    .fetch_fault (fetch_fault),
`ifdef FETCH_SEQ_PERF_EN
    .perf_stall_cycles (perf_stall_cycles),
    .perf_redirects    (perf_redirects),
`endif
    .seq_state   (seq_state)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    chk(nm, 32'(act), 32'(exp));
  endtask

  // Behavioural model
  logic m_booted, m_halted, m_fault, m_waiting, m_shadow;
  int   m_wait_n, m_flush_left;

  initial begin : model
    logic hz, redir;
    logic e_req, e_stall, e_succ, e_fifid, e_fidex, e_sifid, e_fault;
    logic [31:0] e_addr;
    int e_state;
    m_booted = 0; m_halted = 0; m_fault = 0; m_waiting = 0; m_shadow = 0;
    m_wait_n = 0; m_flush_left = 0;
`ifdef FETCH_SEQ_PERF_EN
    m_perf_stall = 0; m_perf_redir = 0;
`endif
    forever begin
      @(negedge clock);
      hz = ex_is_load && (ex_rd != 0) &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
      redir = br_valid && br_taken;
      e_req = 0; e_stall = 0; e_succ = 0; e_fifid = 0; e_fidex = 0; e_sifid = 0;
      e_addr = 0;
      if (reset) begin
        m_booted = 0; m_halted = 0; m_fault = 0; m_waiting = 0; m_shadow = 0;
        m_wait_n = 0; m_flush_left = 0;
`ifdef FETCH_SEQ_PERF_EN
        m_perf_stall = 0; m_perf_redir = 0;
`endif
      end
      e_state = !m_booted ? 0 : m_halted ? 5 : (m_flush_left > 0) ? 4 :
                m_waiting ? 3 : m_shadow ? 2 : 1;
      e_fault = m_fault;
      if (reset) begin
        e_stall = 1;
      end else if (!m_booted) begin
        e_stall = 1;
        m_booted = 1;
      end else if (m_halted) begin
        e_stall = 1; e_sifid = 1; e_fidex = 1;
      end else if (m_flush_left > 0) begin
        e_req = 1; e_fifid = 1;
        if (!imem_ready) e_stall = 1;
        else m_flush_left--;
      end else begin
        e_req = 1;
        if (redir) begin
          e_succ = 1; e_addr = br_offset; e_fifid = 1; e_fidex = 1;
          m_flush_left = BP - 1; m_waiting = 0; m_shadow = 0;
        end else if (m_waiting && imem_ready) begin
          m_waiting = 0;
        end else if (!imem_ready) begin
          e_stall = 1; e_sifid = 1; e_fidex = 1; m_shadow = 0;
          if (m_waiting) begin
            m_wait_n++;
            if (m_wait_n >= MT) begin
              m_halted = 1; m_fault = 1; m_waiting = 0;
            end
          end else begin
            m_waiting = 1; m_wait_n = 1;
          end
        end else if (hz && !m_shadow) begin
          e_stall = 1; e_sifid = 1; e_fidex = 1; m_shadow = 1;
        end else begin
          m_shadow = 0;
        end
      end
      chkb("imem_req", imem_req, e_req);
      chkb("pc_stall", pc_stall, e_stall);
      chkb("pc_succ", pc_succ, e_succ);
      chk ("pc_new_addr", pc_new_addr, e_addr);
      chkb("flush_ifid", flush_ifid, e_fifid);
      chkb("flush_idex", flush_idex, e_fidex);
      chkb("stall_ifid", stall_ifid, e_sifid);
      chkb("fetch_fault", fetch_fault, e_fault);
      chk ("seq_state", 32'(seq_state), 32'(e_state));
      chkb("succ_stall_excl", pc_succ & pc_stall, 1'b0);
`ifdef FETCH_SEQ_PERF_EN
      chk("perf_stall_cycles", perf_stall_cycles, m_perf_stall);
      chk("perf_redirects", perf_redirects, m_perf_redir);
      if (!reset && e_state != 0 && e_stall && m_perf_stall != 32'hFFFF_FFFF)
        m_perf_stall++;
      if (e_succ && m_perf_redir != 32'hFFFF_FFFF)
        m_perf_redir++;
`endif
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_hz();
    ex_is_load = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0;
  endtask

  initial begin
    reset = 1; imem_ready = 1; clear_hz();
    br_valid = 0; br_taken = 0; br_offset = 0;

    @(negedge clock);
    chk ("L_reset_state", 32'(seq_state), 32'd0);
    chkb("L_reset_stall", pc_stall, 1'b1);
    chkb("L_reset_req", imem_req, 1'b0);
    step(); reset = 0;
    @(negedge clock);
    chk ("L_boot_state", 32'(seq_state), 32'd0);
    chkb("L_boot_stall", pc_stall, 1'b1);
    chkb("L_boot_req", imem_req, 1'b0);
    step(); @(negedge clock);
    chk ("L_run_state", 32'(seq_state), 32'd1);
    chkb("L_run_stall", pc_stall, 1'b0);
    chkb("L_run_req", imem_req, 1'b1);

    // Load-use through rs1
    step(); ex_is_load = 1; ex_rd = 5; id_uses_rs1 = 1; id_rs1 = 5;
    @(negedge clock);
    chkb("L_lu_stall", pc_stall, 1'b1);
    chkb("L_lu_sifid", stall_ifid, 1'b1);
    chkb("L_lu_fidex", flush_idex, 1'b1);
    step(); @(negedge clock);
    chk ("L_lu_state", 32'(seq_state), 32'd2);
    chkb("L_lu_no_restall", pc_stall, 1'b0);
    step(); ex_rd = 0; id_rs1 = 0;
    @(negedge clock);
    chkb("L_x0_no_stall", pc_stall, 1'b0);
    step(); ex_rd = 7; id_rs1 = 3; id_rs2 = 7; id_uses_rs2 = 0;
    @(negedge clock);
    chkb("L_rs2_unused", pc_stall, 1'b0);
    step(); id_uses_rs2 = 1;
    @(negedge clock);
    chkb("L_rs2_stall", pc_stall, 1'b1);
    step(); clear_hz();
    @(negedge clock);
    chk ("L_rs2_lu_state", 32'(seq_state), 32'd2);

    // Taken branch with a simultaneous hazard; br_valid during FLUSH ignored
    step(); ex_is_load = 1; ex_rd = 5; id_uses_rs1 = 1; id_rs1 = 5;
    br_valid = 1; br_taken = 1; br_offset = 32'h10;
    @(negedge clock);
    chkb("L_br_succ", pc_succ, 1'b1);
    chk ("L_br_addr", pc_new_addr, 32'h10);
    chkb("L_br_fifid", flush_ifid, 1'b1);
    chkb("L_br_fidex", flush_idex, 1'b1);
    chkb("L_br_stall", pc_stall, 1'b0);
    step(); clear_hz(); br_offset = 32'h20;
    @(negedge clock);
    chk ("L_fl_state", 32'(seq_state), 32'd4);
    chkb("L_fl_succ", pc_succ, 1'b0);
    chkb("L_fl_fifid", flush_ifid, 1'b1);
    step(); br_valid = 0; br_taken = 0;
    @(negedge clock);
    chk ("L_fl_done", 32'(seq_state), 32'd1);
    step(); br_valid = 1; br_taken = 0;
    @(negedge clock);
    chkb("L_not_taken", pc_succ, 1'b0);

    // Three not-ready cycles, then resume
    step(); br_valid = 0; imem_ready = 0;
    @(negedge clock);
    chkb("L_mw_enter_stall", pc_stall, 1'b1);
    step(); step();
    @(negedge clock);
    chk ("L_mw_state", 32'(seq_state), 32'd3);
    chkb("L_mw_stall", pc_stall, 1'b1);
    step(); imem_ready = 1;
    @(negedge clock);
    chkb("L_mw_ready_stall", pc_stall, 1'b0);
    step(); @(negedge clock);
    chk ("L_mw_resume", 32'(seq_state), 32'd1);
    chkb("L_mw_nofault", fetch_fault, 1'b0);

    // Branch while waiting on memory, then FLUSH held by not-ready
    step(); imem_ready = 0;
    step(); br_valid = 1; br_taken = 1; br_offset = 32'h40;
    @(negedge clock);
    chkb("L_mwbr_succ", pc_succ, 1'b1);
    chk ("L_mwbr_addr", pc_new_addr, 32'h40);
    step(); br_valid = 0; br_taken = 0;
    @(negedge clock);
    chk ("L_flhold_state", 32'(seq_state), 32'd4);
    chkb("L_flhold_stall", pc_stall, 1'b1);
    step(); imem_ready = 1;
    step(); @(negedge clock);
    chk ("L_flhold_done", 32'(seq_state), 32'd1);

    // Fetch timeout
    step(); imem_ready = 0;
    repeat (13) step();
    step(); @(negedge clock);
    chk ("L_to_pre_state", 32'(seq_state), 32'd3);
    chkb("L_to_pre_fault", fetch_fault, 1'b0);
    step(); @(negedge clock);
    chk ("L_halt_state", 32'(seq_state), 32'd5);
    chkb("L_halt_fault", fetch_fault, 1'b1);
    chkb("L_halt_req", imem_req, 1'b0);
    step(); imem_ready = 1;
    @(negedge clock);
    chk ("L_halt_sticky", 32'(seq_state), 32'd5);
    step(); reset = 1;
    @(negedge clock);
    chk ("L_rst_halt_state", 32'(seq_state), 32'd0);
    chkb("L_rst_halt_fault", fetch_fault, 1'b0);
    step(); reset = 0;
    step(); @(negedge clock);
    chk ("L_rerun_state", 32'(seq_state), 32'd1);

`ifdef FETCH_SEQ_PERF_EN
    step(); imem_ready = 0;
    step(); step();
    step(); imem_ready = 1;
    step(); br_valid = 1; br_taken = 1; br_offset = 32'h10;
    step(); br_valid = 0; br_taken = 0;
    step(); @(negedge clock);
    chk("L_perf_stall", perf_stall_cycles, 32'd3);
    chk("L_perf_redir", perf_redirects, 32'd1);
    step(); imem_ready = 0;
    force dut.perf_stall_cycles_q = 32'hFFFF_FFFF;
    m_perf_stall = 32'hFFFF_FFFF;
    #1 release dut.perf_stall_cycles_q;
    @(negedge clock);
    chk("L_perf_forced", perf_stall_cycles, 32'hFFFF_FFFF);
    step(); @(negedge clock);
    chk("L_perf_sat", perf_stall_cycles, 32'hFFFF_FFFF);
    step(); imem_ready = 1;
`endif

    step(); step();
    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
